reorder_in: RTL and testbench
=============================

Name: reorder_in

Overview:
- Input-side reorder buffer for the NTT datapath, the counterpart of the output reorder stage.
- Accepts N = 2^NUM_STAGES coefficients in natural order, one per handshake, and stores them.
- Then emits N/2 butterfly operand pairs (x[k], x[k+N/2]) for the first DIF stage.
- Runs once per reset: LOAD phase, DRAIN phase, then DONE.

Parameters:
NUM_STAGES, 4, log2 of transform length N; N = 2^NUM_STAGES, valid range 2..10
DATA_W, 16, coefficient width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data carries a coefficient this cycle
in_data  input  DATA_W  coefficient, natural order x[0]..x[N-1]
in_ready  output  1  block accepts a coefficient this cycle
out_valid  output  1  data_top/data_bot hold a valid pair
out_ready  input  1  downstream butterfly consumes the pair this cycle
data_top  output  DATA_W  x[k]
data_bot  output  DATA_W  x[k+N/2]
pair_idx  output  NUM_STAGES-1  k of the presented pair
in_done  output  1  all N coefficients stored (sticky)
out_done  output  1  all N/2 pairs consumed (sticky)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - Outputs: in_ready=0, out_valid=0, data_top=0, data_bot=0, pair_idx=0, in_done=0, out_done=0.
  - State: FSM=LOAD, wr_cnt=0, rd_cnt=0.
  - Buffer contents are not cleared.
- in_ready is registered:
  - It becomes 1 on the first cycle after reset deasserts.
  - It is 1 only while in LOAD.
- FSM states: LOAD, DRAIN, DONE. Transitions happen only on clk edges with reset low.
- LOAD:
  - Accept when in_valid && in_ready. On accept: buf[wr_cnt] <= in_data and wr_cnt++ (NUM_STAGES bits).
  - in_valid low means a stall. Nothing changes.
  - On the accept where wr_cnt==N-1: in_ready<=0, in_done<=1, go to DRAIN.
  - wr_cnt wraps to 0 at that point, but no further writes occur.
- DRAIN, load condition: (!out_valid || out_ready) && rd_cnt < N/2. rd_cnt has NUM_STAGES bits, so it can represent N/2.
- DRAIN, on the load condition:
  - data_top<=buf[rd_cnt], data_bot<=buf[rd_cnt+N/2], pair_idx<=rd_cnt[NUM_STAGES-2:0].
  - out_valid<=1, rd_cnt++.
- Latency: the first pair is valid 1 cycle after in_done rises. The first DRAIN cycle loads pair 0.
- Throughput: one pair per cycle while out_ready is held high.
- Backpressure: while out_valid && !out_ready, data_top, data_bot and pair_idx hold stable.
- DRAIN exit: when out_valid && out_ready && rd_cnt==N/2 (the last pair is consumed): out_valid<=0, out_done<=1, go to DONE.
- DONE:
  - in_ready=0, out_valid=0, flags stay high.
  - in_valid and out_ready are ignored.
  - Only reset leaves DONE.
- in_valid during DRAIN or DONE is ignored; in_ready is 0.
- out_ready while out_valid=0 has no effect.
- Reset mid-LOAD or mid-DRAIN:
  - Next cycle all state returns to reset values.
  - A partial load is discarded. Coefficients must be resent from x[0].
- Reset has priority over every handshake in the same cycle.
- Buffer:
  - Storage is a register array.
  - One write port in LOAD and two read ports in DRAIN; they are never active in the same cycle.
  - Read addresses: rd_cnt for the top half, and {1'b1, rd_cnt[NUM_STAGES-2:0]} for the bottom half.

Decomposition:
- ntt_pkg holds:
  - localparam N and HALF_N derived from NUM_STAGES.
  - typedef enum logic [1:0] {LOAD, DRAIN, DONE} reorder_state_t, shared with the output reorder stage.
- Sub-module pair_buffer: parameterised register array with one write port and two combinational read ports (top/bot address).
- reorder_in contains the FSM, counters and output registers.

Test Plan:
- N=16, DATA_W=16, in_valid held high, in_data=0..15, out_ready=1:
  - in_done rises after 16 accepts.
  - Pairs are (0,8),(1,9)..(7,15), pair_idx 0..7, on 8 consecutive cycles.
  - out_done rises the cycle after pair 7 is consumed.
- in_valid toggling 1,0,1,0 with data 100+i: stored values stay exact; pair 3 is (103,111).
- out_ready low for 3 cycles while pair 2 is presented:
  - data_top=2 and data_bot=10 are held.
  - No pair is skipped or duplicated; pair 3 follows once out_ready=1.
- Reset asserted after 9 accepts: next cycle in_ready=1, in_done=0. Reloading 50..65 yields first pair (50,58).
- Reset asserted during DRAIN at pair 4: out_valid=0 and out_done=0 next cycle; a fresh load drains from pair 0.
- In DONE, drive in_valid=1 and out_ready=1 for 5 cycles: no state change, flags remain 1, out_valid=0.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions.
//   reorder_state_t : phase encoding used by the input and output reorder stages
//   N / HALF_N      : transform length for the default 4-stage configuration
//   n_of / half_n_of: derive the transform length from a module's NUM_STAGES
package ntt_pkg;

  localparam int unsigned NUM_STAGES_DEFAULT = 4;
  localparam int unsigned N                  = 32'd1 << NUM_STAGES_DEFAULT;
  localparam int unsigned HALF_N             = N / 2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } reorder_state_t;

  function automatic int unsigned n_of(input int unsigned stages);
    return 32'd1 << stages;
  endfunction

  function automatic int unsigned half_n_of(input int unsigned stages);
    return (32'd1 << stages) >> 1;
  endfunction

endpackage

// File: rtl/reorder_in_if.sv
// Handshake bundle of the input reorder buffer.
//   in_valid/in_data/in_ready          : coefficient stream, natural order
//   out_valid/out_ready                : butterfly pair stream
//   data_top/data_bot/pair_idx         : pair (x[k], x[k+N/2]) and its k
// slave modport is the reorder block, master is the surrounding datapath.
interface reorder_in_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_STAGES = 4
);

  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       data_top;
  logic [DATA_W-1:0]       data_bot;
  logic [NUM_STAGES-2:0]   pair_idx;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, data_top, data_bot, pair_idx
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, data_top, data_bot, pair_idx
  );

endinterface

// File: rtl/reorder_in_pair_buffer.sv
// Register array with one synchronous write port and two combinational
// read ports (top/bottom half of the butterfly pair). Contents are not reset.
//   clk              : clock
//   we/waddr/wdata   : write port
//   raddr_top/_bot   : read addresses
//   rdata_top/_bot   : read data
module pair_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_top,
  input  logic [ADDR_W-1:0] raddr_bot,
  output logic [DATA_W-1:0] rdata_top,
  output logic [DATA_W-1:0] rdata_bot
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_top = mem[raddr_top];
  assign rdata_bot = mem[raddr_bot];

endmodule

// File: rtl/reorder_in.sv
// Input-side reorder buffer for the NTT datapath. Loads N = 2^NUM_STAGES
// coefficients in natural order, then emits N/2 pairs (x[k], x[k+N/2]) for
// the first DIF stage. Runs once per reset: LOAD -> DRAIN -> DONE.
//   clk, reset : clock, synchronous active-high reset
//   bus        : coefficient input and pair output handshakes
//   in_done    : all N coefficients stored (sticky)
//   out_done   : all N/2 pairs consumed (sticky)
module reorder_in
  import ntt_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DATA_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  reorder_in_if.slave  bus,
  output logic         in_done,
  output logic         out_done
);

  localparam logic [NUM_STAGES-1:0] HALF_CNT = NUM_STAGES'(half_n_of(NUM_STAGES));

  reorder_state_t        state, state_next;
  logic [NUM_STAGES-1:0] wr_cnt;
  logic [NUM_STAGES-1:0] rd_cnt;
  logic                  accept;
  logic                  last_accept;
  logic                  load_pair;
  logic                  drain_exit;
  logic [DATA_W-1:0]     rdata_top;
  logic [DATA_W-1:0]     rdata_bot;

  pair_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (NUM_STAGES)
  ) u_buf (
    .clk       (clk),
    .we        (accept),
    .waddr     (wr_cnt),
    .wdata     (bus.in_data),
    .raddr_top (rd_cnt),
    .raddr_bot ({1'b1, rd_cnt[NUM_STAGES-2:0]}),
    .rdata_top (rdata_top),
    .rdata_bot (rdata_bot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // rd_cnt counts pairs loaded into the output registers, so it reaches
  // HALF_CNT while the final pair is still being presented; the exit waits
  // for that pair's handshake.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    last_accept = 1'b0;
    load_pair   = 1'b0;
    drain_exit  = 1'b0;
    unique case (state)
      LOAD: begin
        accept      = bus.in_valid && bus.in_ready;
        last_accept = accept && (wr_cnt == '1);
        if (last_accept) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        load_pair  = (!bus.out_valid || bus.out_ready) && (rd_cnt < HALF_CNT);
        drain_exit = bus.out_valid && bus.out_ready && (rd_cnt == HALF_CNT);
        if (drain_exit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.data_top  <= '0;
      bus.data_bot  <= '0;
      bus.pair_idx  <= '0;
      in_done       <= 1'b0;
      out_done      <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
    end else begin
      bus.in_ready <= (state_next == LOAD);
      if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (last_accept) begin
        in_done <= 1'b1;
      end
      if (load_pair) begin
        bus.data_top  <= rdata_top;
        bus.data_bot  <= rdata_bot;
        bus.pair_idx  <= rd_cnt[NUM_STAGES-2:0];
        bus.out_valid <= 1'b1;
        rd_cnt        <= rd_cnt + 1'b1;
      end else if (drain_exit) begin
        bus.out_valid <= 1'b0;
        out_done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reorder_in.sv
module tb_reorder_in;

  localparam int unsigned NS     = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned NN     = 16;
  localparam int unsigned HALF   = 8;

  typedef struct {
    logic [DW-1:0] top;
    logic [DW-1:0] bot;
    int unsigned   idx;
  } pair_t;

  logic clk;
  logic reset;
  logic in_done;
  logic out_done;

  reorder_in_if #(.DATA_W(DW), .NUM_STAGES(NS)) bus ();

  reorder_in #(.NUM_STAGES(NS), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .in_done  (in_done),
    .out_done (out_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  pair_t         sb[$];
  logic [DW-1:0] loaded [NN];
  int unsigned   wr = 0;
  int unsigned   consumed = 0;
  int unsigned   cyc = 0;
  int unsigned   first_pop = 0;
  int unsigned   last_pop = 0;
  logic          exp_in_done = 1'b0;
  logic          exp_out_done = 1'b0;
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_top, hold_bot;
  int unsigned   hold_idx;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, advance the reference model for the coming
  // edge, then sample outputs 1ns after the edge and compare.
  task automatic cycle(input logic rst, input logic iv, input logic [DW-1:0] id,
                       input logic ordy);
    logic  was_drain;
    logic  exp_ov;
    pair_t p;
    if (hold_pending) begin
      check("hold_top", bus.data_top, hold_top);
      check("hold_bot", bus.data_bot, hold_bot);
      check("hold_idx", bus.pair_idx, hold_idx);
    end
    hold_pending  = 1'b0;
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    was_drain     = exp_in_done && !exp_out_done;
    if (rst) begin
      wr           = 0;
      consumed     = 0;
      exp_in_done  = 1'b0;
      exp_out_done = 1'b0;
      sb.delete();
    end else begin
      if (iv && bus.in_ready) begin
        loaded[wr] = id;
        wr++;
        if (wr == NN) begin
          exp_in_done = 1'b1;
          for (int k = 0; k < HALF; k++) begin
            p.top = loaded[k];
            p.bot = loaded[k + HALF];
            p.idx = k;
            sb.push_back(p);
          end
        end
      end
      if (bus.out_valid && ordy) begin
        if (sb.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          p = sb.pop_front();
          check("data_top", bus.data_top, p.top);
          check("data_bot", bus.data_bot, p.bot);
          check("pair_idx", bus.pair_idx, p.idx);
        end
        consumed++;
        if (consumed == 1) first_pop = cyc;
        last_pop = cyc;
        if (consumed == HALF) exp_out_done = 1'b1;
      end else if (bus.out_valid) begin
        hold_pending = 1'b1;
        hold_top     = bus.data_top;
        hold_bot     = bus.data_bot;
        hold_idx     = bus.pair_idx;
      end
    end
    exp_ov = !rst && was_drain && (sb.size() > 0);
    @(posedge clk);
    #1;
    cyc++;
    check("in_ready", bus.in_ready, (!rst && !exp_in_done) ? 1 : 0);
    check("in_done", in_done, exp_in_done);
    check("out_done", out_done, exp_out_done);
    check("out_valid", bus.out_valid, exp_ov);
  endtask

  task automatic load_seq(input int unsigned base, input bit toggle);
    int unsigned n = 0;
    while (wr < NN && n < 100) begin
      cycle(1'b0, toggle ? ((n % 2) == 0) : 1'b1, DW'(base + wr), 1'b1);
      n++;
    end
    check("load_done", in_done, 1);
  endtask

  task automatic drain(input int unsigned stall_idx, input int unsigned stall_len);
    int unsigned n = 0;
    int unsigned stalled = 0;
    logic ordy;
    while (!out_done && n < 100) begin
      ordy = 1'b1;
      if (bus.out_valid && bus.pair_idx == stall_idx && stalled < stall_len) begin
        ordy = 1'b0;
        stalled++;
      end
      cycle(1'b0, 1'b0, '0, ordy);
      n++;
    end
    check("drain_done", out_done, 1);
    check("sb_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset values
    cycle(1'b1, 1'b1, 16'h1234, 1'b1);
    check("rst_top", bus.data_top, 0);
    check("rst_bot", bus.data_bot, 0);
    check("rst_idx", bus.pair_idx, 0);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // streaming load 0..15, full-rate drain
    load_seq(0, 1'b0);
    drain(99, 0);
    check("drain_span", last_pop - first_pop, HALF - 1);

    // DONE ignores handshakes
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'hAAAA, 1'b1);
    check("done_top", bus.data_top, 7);

    // toggling in_valid, data 100+i
    do_reset();
    load_seq(100, 1'b1);
    drain(99, 0);

    // backpressure on pair 2
    do_reset();
    load_seq(0, 1'b0);
    drain(2, 3);

    // reset mid-load after 9 accepts, then reload 50..65
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, DW'(200 + i), 1'b1);
    check("partial_wr", wr, 9);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("reload_rdy", bus.in_ready, 1);
    load_seq(50, 1'b0);
    drain(99, 0);

    // reset during drain at pair 4, then fresh run
    do_reset();
    load_seq(300, 1'b0);
    for (int n = 0; n < 30 && !(bus.out_valid && bus.pair_idx == 4); n++)
      cycle(1'b0, 1'b0, '0, 1'b1);
    check("at_pair4", bus.pair_idx, 4);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("rst_drain_ov", bus.out_valid, 0);
    check("rst_drain_od", out_done, 0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    load_seq(400, 1'b0);
    drain(99, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
